// File: rtl/qam_pkg.sv
// Shared widths and packer state encoding for the 16-QAM symbol-to-byte path.
package qam_pkg;

  localparam int unsigned SYM_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

endpackage

// File: rtl/qam_byte_fifo.sv
// Show-ahead byte FIFO with power-of-two depth; pointers wrap naturally.
module qam_byte_fifo
  import qam_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [BYTE_W-1:0]         i_din,
  input  logic                      i_pop,
  output logic [BYTE_W-1:0]         o_dout,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_pop;
  logic              w_push;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  // A pop on a full FIFO frees the slot the same-cycle push needs.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/qam_symbol_packer.sv
// Packs pairs of demapped 16-QAM symbols into bytes (first symbol in the high
// nibble), queues them in a show-ahead FIFO and marks frame boundaries.
module qam_symbol_packer
  import qam_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FRAME_BYTES = 50
) (
  input  logic                      sclk,
  input  logic                      reset_n,
  input  logic [SYM_W-1:0]          sym_in,
  input  logic                      sym_valid,
  input  logic                      flush,
  input  logic                      byte_read,
  output logic [BYTE_W-1:0]         byte_out,
  output logic                      byte_valid,
  output logic                      frame_done,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    fill_level
);

  localparam int unsigned CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);

  pack_state_t       r_state;
  pack_state_t       w_state_nxt;
  logic [SYM_W-1:0]  r_held;
  logic [SYM_W-1:0]  w_held_nxt;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic              r_frame_done;
  logic              r_overflow;
  logic              w_push;
  logic [BYTE_W-1:0] w_byte;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_push      = 1'b0;
    w_byte      = '0;
    case (r_state)
      EMPTY: begin
        if (sym_valid) begin
          if (flush) begin
            w_push = 1'b1;
            w_byte = {sym_in, {SYM_W{1'b0}}};
          end else begin
            w_held_nxt  = sym_in;
            w_state_nxt = HALF;
          end
        end
      end
      HALF: begin
        // A valid symbol completes the byte, so a concurrent flush adds no pad.
        if (sym_valid) begin
          w_push      = 1'b1;
          w_byte      = {r_held, sym_in};
          w_held_nxt  = '0;
          w_state_nxt = EMPTY;
        end else if (flush) begin
          w_push      = 1'b1;
          w_byte      = {r_held, {SYM_W{1'b0}}};
          w_held_nxt  = '0;
          w_state_nxt = EMPTY;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_held_nxt  = '0;
      end
    endcase
  end

  assign w_pop  = byte_read & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= EMPTY;
      r_held       <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_held       <= w_held_nxt;
      r_frame_done <= 1'b0;
      // Dropped bytes still belong to the frame, so count every attempt.
      if (w_push) begin
        if (r_frame_cnt == LAST_CNT) begin
          r_frame_cnt  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  qam_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sclk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_din   (w_byte),
    .i_pop   (byte_read),
    .o_dout  (byte_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fill_level)
  );

  assign byte_valid = ~w_empty;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_qam_symbol_packer.sv
// Scoreboard bench for qam_symbol_packer: a nibble-packing model feeds an
// expected-byte queue that is compared against the FIFO head as bytes are read.
module tb_qam_symbol_packer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned FB    = 50;

  logic                   sclk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [3:0]             sym_in = '0;
  logic                   sym_valid = 1'b0;
  logic                   flush = 1'b0;
  logic                   byte_read = 1'b0;
  logic [7:0]             byte_out;
  logic                   byte_valid;
  logic                   frame_done;
  logic                   overflow;
  logic [$clog2(DEPTH):0] fill_level;

  always #5 sclk = ~sclk;

  qam_symbol_packer #(
    .DEPTH       (DEPTH),
    .FRAME_BYTES (FB)
  ) dut (
    .sclk       (sclk),
    .reset_n    (reset_n),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .flush      (flush),
    .byte_read  (byte_read),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_done (frame_done),
    .overflow   (overflow),
    .fill_level (fill_level)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  bit         m_half = 1'b0;
  logic [3:0] m_held = '0;
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  int         m_fcnt = 0;
  bit         m_fdone = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, ".valid"},    32'(byte_valid), 32'(q.size() != 0));
    chk({tag, ".level"},    32'(fill_level), 32'(q.size()));
    chk({tag, ".byte"},     32'(byte_out),   32'(head));
    chk({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
    chk({tag, ".frame"},    32'(frame_done), 32'(m_fdone));
  endtask

  // Called just after a falling edge: drive, predict the next rising edge, check.
  task automatic cyc(input bit sv, input logic [3:0] s, input bit fl, input bit rd);
    bit         push;
    bit         pop;
    logic [7:0] pb;
    sym_valid = sv;
    sym_in    = s;
    flush     = fl;
    byte_read = rd;
    push = 1'b0;
    pb   = 8'h00;
    if (!m_half) begin
      if (sv) begin
        if (fl) begin
          push = 1'b1;
          pb   = {s, 4'h0};
        end else begin
          m_half = 1'b1;
          m_held = s;
        end
      end
    end else if (sv) begin
      push   = 1'b1;
      pb     = {m_held, s};
      m_half = 1'b0;
    end else if (fl) begin
      push   = 1'b1;
      pb     = {m_held, 4'h0};
      m_half = 1'b0;
    end
    pop = rd && (q.size() > 0);
    if (pop) begin
      chk("pop_head", 32'(byte_out), 32'(q[0]));
      void'(q.pop_front());
    end
    if (push) begin
      if (q.size() < int'(DEPTH)) q.push_back(pb);
      else m_ovf = 1'b1;
    end
    m_fdone = 1'b0;
    if (push) begin
      if (m_fcnt == int'(FB) - 1) begin
        m_fcnt  = 0;
        m_fdone = 1'b1;
      end else begin
        m_fcnt++;
      end
    end
    @(negedge sclk);
    check_outs("cyc");
    if (frame_done) n_pulses++;
  endtask

  task automatic do_reset();
    #2;
    reset_n   = 1'b0;
    sym_valid = 1'b0;
    sym_in    = '0;
    flush     = 1'b0;
    byte_read = 1'b0;
    #1;
    m_half  = 1'b0;
    m_held  = '0;
    q.delete();
    m_ovf   = 1'b0;
    m_fcnt  = 0;
    m_fdone = 1'b0;
    check_outs("reset");
    @(negedge sclk);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 1; i++) cyc(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset();

    // First nibble right after release must be accepted.
    cyc(1'b1, 4'hA, 1'b0, 1'b0);
    chk("a5_not_yet", 32'(byte_valid), 32'd0);
    cyc(1'b1, 4'h5, 1'b0, 1'b0);
    chk("a5_byte",  32'(byte_out),   32'h A5);
    chk("a5_level", 32'(fill_level), 32'd1);
    drain();

    // Flush variants.
    cyc(1'b1, 4'h3, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("flush_half", 32'(byte_out), 32'h30);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b1, 4'h7, 1'b1, 1'b0);
    chk("flush_sym_empty", 32'(byte_out), 32'h70);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("flush_idle_level", 32'(fill_level), 32'd0);
    cyc(1'b1, 4'h9, 1'b0, 1'b0);
    cyc(1'b1, 4'h2, 1'b1, 1'b0);
    chk("flush_sym_half", 32'(byte_out), 32'h92);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("flush_sym_half_nopad", 32'(fill_level), 32'd1);
    drain();

    // Fill past capacity, then push+pop while full.
    for (int i = 0; i < 18; i++) cyc(1'b1, 4'(i + 1), 1'b0, 1'b0);
    chk("full_level", 32'(fill_level), 32'(DEPTH));
    chk("full_ovf",   32'(overflow),   32'd1);
    chk("full_head",  32'(byte_out),   32'h12);
    cyc(1'b1, 4'h4, 1'b1, 1'b1);
    chk("full_pushpop_level", 32'(fill_level), 32'(DEPTH));
    chk("full_pushpop_head",  32'(byte_out),   32'h34);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset while holding a nibble with bytes queued.
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i + 8), 1'b0, 1'b0);
    cyc(1'b1, 4'hE, 1'b0, 1'b0);
    chk("pre_reset_level", 32'(fill_level), 32'd3);
    do_reset();
    cyc(1'b1, 4'hC, 1'b0, 1'b0);
    cyc(1'b1, 4'h1, 1'b0, 1'b0);
    chk("post_reset_byte", 32'(byte_out), 32'hC1);

    // One full frame from a clean counter.
    do_reset();
    n_pulses = 0;
    for (int i = 0; i < 100; i++) cyc(1'b1, 4'(i * 7), 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("frame_pulses", 32'(n_pulses), 32'd1);

    // Streaming read across pointer wrap.
    for (int i = 0; i < 40; i++) cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
    chk("stream_no_ovf", 32'(overflow), 32'd0);

    // Random mix including empty reads and overflow.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
